// File: rtl/seq_shifter.sv
// seq_shifter: 16-bit shift/rotate by 0-15 positions, one bit per clock,
// with valid/ready request and response ports.
`default_nettype none

module shift1 (
  input  logic [15:0] data_i,
  input  logic [1:0]  op_i,
  input  logic        sh_i,
  output logic [15:0] data_o
);

  logic [15:0] stepped;

  always_comb begin
    stepped = data_i;
    case (op_i)
      2'b00:   stepped = {data_i[14:0], data_i[15]};
      2'b01:   stepped = {data_i[14:0], 1'b0};
      2'b10:   stepped = {data_i[15], data_i[15:1]};
      default: stepped = {1'b0, data_i[15:1]};
    endcase
  end

  assign data_o = sh_i ? stepped : data_i;

endmodule

module seq_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_cnt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] data_q;
  logic [1:0]  op_q;
  logic [3:0]  cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [15:0] data_d;

  shift1 u_shift1 (
    .data_i (data_q),
    .op_i   (op_q),
    .sh_i   (1'b1),
    .data_o (data_d)
  );

  // Handshake outputs are registered alongside the state so they always
  // reflect the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= 16'h0000;
      op_q        <= 2'b00;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            op_q       <= in_op;
            cnt_q      <= in_cnt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (in_cnt == 4'd0) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter against an arithmetic reference model.
`default_nettype none

module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int checks;
  int failures;

  seq_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                            input int n);
    logic [31:0] wide;
    wide = {16'h0000, d};
    case (op)
      2'b00:   ref_shift = 16'((wide << n) | (wide >> (16 - n)));
      2'b01:   ref_shift = 16'(wide << n);
      2'b10:   ref_shift = 16'($signed(d) >>> n);
      default: ref_shift = 16'(wide >> n);
    endcase
  endfunction

  // Presents one request at the current negedge, measures latency, checks the
  // result, then hands it off with out_ready.
  task automatic run_req(input logic [15:0] d, input logic [1:0] op, input logic [3:0] n,
                         input string name);
    int cycles;
    logic [15:0] exp;
    exp = ref_shift(d, op, int'(n));
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, in_ready);
    end
    in_valid = 1'b1; in_data = d; in_op = op; in_cnt = n;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_accept got busy=%b in_ready=%b want 1/0", name, busy, in_ready);
    end
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (out_valid !== 1'b1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_during_shift got=%b want=1", name, busy);
        end
      end
    end
    checks++;
    if (cycles != int'(n) || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, cycles, n);
    end
    checks++;
    if (out_data !== exp) begin
      failures++;
      $display("FAIL %s data got=%h want=%h (d=%h op=%0d n=%0d)", name, out_data, exp, d, op, n);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s handoff got in_ready=%b out_valid=%b busy=%b want 1/0/0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_cnt = 4'd0; in_op = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b busy=%b data=%h want 1/0/0/0000",
               in_ready, out_valid, busy, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_req(16'h8001, 2'b00, 4'd4,  "rotl_8001_4");
    run_req(16'h8000, 2'b10, 4'd15, "asr_8000_15");
    run_req(16'h8000, 2'b11, 4'd15, "lsr_8000_15");
    run_req(16'h00FF, 2'b01, 4'd8,  "lsl_00ff_8");
    run_req(16'h1234, 2'b10, 4'd0,  "zero_cnt");
    run_req(16'hBEEF, 2'b00, 4'd15, "rotl_max");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_req(16'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    int cycles;
    exp = ref_shift(16'hC3A5, 2'b10, 3);
    in_valid = 1'b1; in_data = 16'hC3A5; in_op = 2'b10; in_cnt = 4'd3;
    @(posedge clk);
    @(negedge clk);
    in_data = 16'h5555; in_op = 2'b01; in_cnt = 4'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != 3) begin
      failures++;
      $display("FAIL bp_latency got=%0d want=3", cycles);
    end
    in_valid = 1'b1; in_data = 16'h0F0F;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b data=%h want 1/0/%h",
                 k, out_valid, in_ready, out_data, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 16'h9ABC; in_op = 2'b00; in_cnt = 4'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid got in_ready=%b out_valid=%b busy=%b data=%h want 1/0/0/0000",
               in_ready, out_valid, busy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req(16'h6E21, 2'b11, 4'd5, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a, exp_b;
    int cycles;
    exp_a = ref_shift(16'hA001, 2'b01, 2);
    exp_b = ref_shift(16'h7F00, 2'b10, 3);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'hA001; in_op = 2'b01; in_cnt = 4'd2;
    @(posedge clk);
    @(negedge clk);
    in_data = 16'h7F00; in_op = 2'b10; in_cnt = 4'd3;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != 2 || out_data !== exp_a) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d data=%h want 2/%h", cycles, out_data, exp_a);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle got in_ready=%b want=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != 3 || out_data !== exp_b) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d data=%h want 3/%h", cycles, out_data, exp_b);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
